// File: rtl/fsm_vd_pkg.sv
// Shared definitions for the mod-N down-counter FSM.
//   MOD_DEFAULT : default number of states (s0..s5)
//   state_e     : 3-bit state encoding; S6/S7 exist so MOD up to 8 can be
//                 expressed, and are illegal codes when MOD = 6
//   SEG7_TABLE  : active-low {g,f,e,d,c,b,a} codes for digits 0-9
//   seg7_code   : table lookup, blank for values above 9
package fsm_vd_pkg;

    localparam int unsigned MOD_DEFAULT = 6;

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100,
        S5 = 3'b101,
        S6 = 3'b110,
        S7 = 3'b111
    } state_e;

    localparam logic [6:0] SEG7_TABLE [10] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    localparam logic [6:0] SEG7_BLANK = 7'b1111111;

    function automatic logic [6:0] seg7_code(input logic [3:0] value);
        if (value < 4'd10) begin
            return SEG7_TABLE[value];
        end
        return SEG7_BLANK;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 7-segment decoder.
//   value : 4-bit binary digit in
//   seg_n : active-low segments {g,f,e,d,c,b,a}; blank for values above 9
module seg7_decoder
    import fsm_vd_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = seg7_code(value);
    end

endmodule

// File: rtl/fsm_vd1_down_counter.sv
// Modulo-MOD down-counting state machine for the DE2 switch/LED labs.
// Steps s(MOD-1) -> ... -> s0 -> s(MOD-1) on each enabled rising SW[2].
//   SW[2]     : clock (manual switch)
//   SW[1]     : synchronous active-low reset
//   SW[0]     : count enable
//   SW[3]     : parallel load of SW[6:4] (clamped to s(MOD-1) if out of range)
//   SW[6:4]   : load value
//   LEDR[2:0] : current state index
//   LEDR[12]  : terminal level, high while in s0
//   LEDR[13]  : wrap pulse, high for the cycle after an s0 -> s(MOD-1) step
//   HEX0      : current state as an active-low 7-segment digit
//   LEDR[11:3] carry no function and are tied low.
module fsm_vd1_down_counter
    import fsm_vd_pkg::*;
#(
    parameter int unsigned MOD = MOD_DEFAULT,
    parameter int unsigned W   = $clog2(MOD)
) (
    input  logic [6:0]  SW,
    output logic [13:0] LEDR,
    output logic [6:0]  HEX0
);

    localparam logic [W-1:0] LAST_IDX = W'(MOD - 1);
    localparam state_e       LAST     = state_e'(3'(LAST_IDX));

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       ld;
    logic [2:0] ld_val;

    assign clk    = SW[2];
    assign rst_n  = SW[1];
    assign en     = SW[0];
    assign ld     = SW[3];
    assign ld_val = SW[6:4];

    state_e state_q;
    state_e state_d;
    logic   wrap_q;
    logic   wrap_d;

    // State and wrap registers; reset has top priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LAST;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next state: load > illegal-code recovery > enable > hold.
    // Codes at or above MOD return to s(MOD-1) on the next clock even when
    // the enable is low, so a corrupted register never lingers.
    always_comb begin
        state_d = state_q;
        wrap_d  = 1'b0;
        if (ld) begin
            state_d = (32'(ld_val) < MOD) ? state_e'(ld_val) : LAST;
        end else if (32'(state_q) >= MOD) begin
            state_d = LAST;
        end else if (en) begin
            case (state_q)
                S0: begin
                    state_d = LAST;
                    wrap_d  = 1'b1;
                end
                S1:      state_d = S0;
                S2:      state_d = S1;
                S3:      state_d = S2;
                S4:      state_d = S3;
                S5:      state_d = S4;
                S6:      state_d = S5;
                S7:      state_d = S6;
                default: state_d = LAST;
            endcase
        end
    end

    // Outputs.
    assign LEDR[2:0]  = state_q;
    assign LEDR[11:3] = '0;
    assign LEDR[12]   = (state_q == S0);
    assign LEDR[13]   = wrap_q;

    seg7_decoder u_seg7 (
        .value ({1'b0, state_q}),
        .seg_n (HEX0)
    );

endmodule
